// File: rtl/vote_pkg.sv
// Shared vote-path definitions: FSM encoding, board constants and the
// one-hot ballot decoder used by the capture and tally logic.
package vote_pkg;

    localparam int N_CAND = 16;
    localparam int CAND_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        CHECK   = 3'd2,
        VALID   = 3'd3,
        RELEASE = 3'd4
    } state_e;

    typedef struct packed {
        logic              ok;
        logic [CAND_W-1:0] idx;
    } ballot_t;

    // ok is set only when exactly one switch is up; idx is its position.
    function automatic ballot_t decode_ballot(input logic [N_CAND-1:0] b);
        ballot_t r;
        int      n;
        r = '0;
        n = 0;
        for (int i = 0; i < N_CAND; i++) begin
            if (b[i]) begin
                n     = n + 1;
                r.idx = CAND_W'(i);
            end
        end
        r.ok = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; each bit is
// synchronized independently.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vote_capture.sv
// Turns the raw candidate switches and cast button into one debounced,
// validated vote transaction per press, offered over valid/ready.
module vote_capture
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_CAND-1:0] sw,
    input  logic              btn_cast,
    output logic              vote_valid,
    output logic [CAND_W-1:0] vote_cand,
    input  logic              vote_ready,
    output logic              vote_err,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [N_CAND-1:0] sw_s;
    logic              btn_s;

    sync_2ff #(.W(N_CAND)) u_sync_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sw),
        .q_o   (sw_s)
    );

    sync_2ff #(.W(1)) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_cast),
        .q_o   (btn_s)
    );

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_CAND-1:0] ballot_q;
    logic              valid_q;
    logic [CAND_W-1:0] cand_q;
    logic              err_q;
    logic              busy_q;
    ballot_t           dec;

    assign dec = decode_ballot(ballot_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ballot_q <= '0;
            valid_q  <= 1'b0;
            cand_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && btn_s) begin
                        cnt_q   <= '0;
                        state_q <= PRESS;
                        busy_q  <= 1'b1;
                    end
                end
                PRESS: begin
                    if (!btn_s || !enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        ballot_q <= sw_s;
                        state_q  <= CHECK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (dec.ok) begin
                        cand_q  <= dec.idx;
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end else begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= RELEASE;
                    end
                end
                VALID: begin
                    // Committed vote: enable no longer matters here.
                    if (vote_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (btn_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vote_valid = valid_q;
    assign vote_cand  = cand_q;
    assign vote_err   = err_q;
    assign busy       = busy_q;

endmodule
